image_ram_arbiter: RTL and testbench

- Shares the single-port image RAM between the display pixel-fetch path and a processor load/store port.
- Display reads have priority. The processor is served in display idle slots (blanking) or in a forced slot after starvation.
- Tracks in-flight reads through the fixed RAM read latency and routes returned data to the correct requester.
- Sits between the pixel fetcher, the processor bus and the image RAM, in the VGA clock domain.

---
 rtl/image_ram_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_image_ram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_ram_arbiter.sv
// image_ram_arbiter
//   Shares the single-port image RAM between the display pixel fetcher and a
//   processor load/store port, in the VGA pixel clock domain. Display reads
//   win by default. The processor gets idle (blanking) slots, or a forced slot
//   once it has been denied STARVE_MAX consecutive cycles. A tag pipeline
//   follows every read through the fixed RAM latency and steers the returned
//   word to the requester that issued it.
//
//   Optional feature macro: IMAGE_RAM_STARVE_GUARD_EN
//     defined   : forced processor slot, starvation counter, underrun counter
//     undefined : processor served only when disp_req is low, underrun_cnt = 0
//
// Ports
//   clk, rst                      pixel clock, asynchronous active-high reset
//   disp_req/disp_addr            display read request (one per cycle)
//   disp_data/disp_valid          display read return, RD_LAT+1 after request
//   cpu_req/cpu_we/cpu_addr/
//   cpu_wdata                     processor request, held until cpu_gnt
//   cpu_gnt                       pulse in the cycle the processor slot is taken
//   cpu_rdata/cpu_rvalid          processor read return, RD_LAT+1 after gnt
//   ram_addr/ram_wdata/ram_we     registered RAM command
//   ram_rdata                     RAM read data, RD_LAT cycles after address
//   underrun_cnt                  saturating count of denied display requests
module image_ram_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [15:0]       underrun_cnt
);

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_DISP  = 2'd1,
    SLOT_CPU   = 2'd2,
    SLOT_FORCE = 2'd3
  } slot_e;

  slot_e             slot_s;
  logic              force_s;
  logic              cpu_sel_s;

  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] last_pix_q, last_pix_d;

  // One bit per tag kind; bit 0 is the issue stage, bit RD_LAT lines up with ram_rdata.
  // A forced slot that denies the display carries a "repeat" tag so the display still
  // gets a valid beat at the usual time.
  logic [RD_LAT:0]   disp_tag_q, disp_tag_d;
  logic [RD_LAT:0]   drep_tag_q, drep_tag_d;
  logic [RD_LAT:0]   cpu_tag_q,  cpu_tag_d;

`ifdef IMAGE_RAM_STARVE_GUARD_EN
  localparam logic [7:0] STARVE_MAX_C = 8'(STARVE_MAX);
  logic [7:0]  starve_cnt_q, starve_cnt_d;
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  assign force_s = cpu_req && (starve_cnt_q == STARVE_MAX_C);
`else
  assign force_s = 1'b0;
`endif

  // Per-cycle slot decision in priority order: forced processor, display, processor.
  always_comb begin
    slot_s = SLOT_IDLE;
    if (force_s) begin
      slot_s = SLOT_FORCE;
    end else if (disp_req) begin
      slot_s = SLOT_DISP;
    end else if (cpu_req) begin
      slot_s = SLOT_CPU;
    end else begin
      slot_s = SLOT_IDLE;
    end
  end

  assign cpu_sel_s = (slot_s == SLOT_CPU) || (slot_s == SLOT_FORCE);
  // Grant is taken in the decision cycle so the requester can drop cpu_req next cycle.
  assign cpu_gnt   = cpu_sel_s && !rst;

  // Next RAM command; address and write data hold through idle slots.
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    case (slot_s)
      SLOT_DISP: begin
        ram_addr_d = disp_addr;
      end
      SLOT_CPU, SLOT_FORCE: begin
        ram_addr_d  = cpu_addr;
        ram_wdata_d = cpu_wdata;
        ram_we_d    = cpu_we;
      end
      default: begin
        ram_we_d = 1'b0;
      end
    endcase
  end

  // Shift the return tags and remember the most recent real display pixel.
  always_comb begin
    disp_tag_d = {disp_tag_q[RD_LAT-1:0], slot_s == SLOT_DISP};
    drep_tag_d = {drep_tag_q[RD_LAT-1:0], (slot_s == SLOT_FORCE) && disp_req};
    cpu_tag_d  = {cpu_tag_q[RD_LAT-1:0], cpu_sel_s && !cpu_we};
    if (disp_tag_q[RD_LAT]) begin
      last_pix_d = ram_rdata;
    end else begin
      last_pix_d = last_pix_q;
    end
  end

`ifdef IMAGE_RAM_STARVE_GUARD_EN
  // Starvation counter clears on grant or idle request; underrun counts denied display reads.
  always_comb begin
    if (!cpu_req || cpu_sel_s) begin
      starve_cnt_d = 8'd0;
    end else if (starve_cnt_q == STARVE_MAX_C) begin
      starve_cnt_d = starve_cnt_q;
    end else begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
    if ((slot_s == SLOT_FORCE) && disp_req && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_d = underrun_cnt_q + 16'd1;
    end else begin
      underrun_cnt_d = underrun_cnt_q;
    end
  end

  // Guard counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q   <= 8'd0;
      underrun_cnt_q <= 16'd0;
    end else begin
      starve_cnt_q   <= starve_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`else
  assign underrun_cnt = 16'd0;
`endif

  // RAM command register, return tags and last-pixel holder; reset drops in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      last_pix_q  <= '0;
      disp_tag_q  <= '0;
      drep_tag_q  <= '0;
      cpu_tag_q   <= '0;
    end else begin
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      last_pix_q  <= last_pix_d;
      disp_tag_q  <= disp_tag_d;
      drep_tag_q  <= drep_tag_d;
      cpu_tag_q   <= cpu_tag_d;
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_we     = ram_we_q;

  assign disp_valid = disp_tag_q[RD_LAT] || drep_tag_q[RD_LAT];
  assign cpu_rvalid = cpu_tag_q[RD_LAT];

  // Route the returning word; a repeat beat replays the last delivered pixel.
  always_comb begin
    if (disp_tag_q[RD_LAT]) begin
      disp_data = ram_rdata;
    end else if (drep_tag_q[RD_LAT]) begin
      disp_data = last_pix_q;
    end else begin
      disp_data = '0;
    end
    if (cpu_tag_q[RD_LAT]) begin
      cpu_rdata = ram_rdata;
    end else begin
      cpu_rdata = '0;
    end
  end

endmodule

// File: tb/tb_image_ram_arbiter.sv
// Bench for image_ram_arbiter: two instances (RD_LAT = 1 and RD_LAT = 3) share
// the same stimulus; each has its own RAM model. A transaction-level model
// predicts grants, writes, underrun count and every return beat per cycle.
module tb_image_ram_arbiter;
  localparam int AW   = 18;
  localparam int DW   = 32;
  localparam int SMAX = 16;
  localparam int NCYC = 512;
`ifdef IMAGE_RAM_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;

  logic [DW-1:0] dd_w [2];
  logic          dv_w [2];
  logic          gnt_w [2];
  logic [DW-1:0] cd_w [2];
  logic          cv_w [2];
  logic [AW-1:0] ra_w [2];
  logic [DW-1:0] wd_w [2];
  logic          we_w [2];
  logic [DW-1:0] rd_w [2];
  logic [15:0]   und_w [2];

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;
  logic last_gnt = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar j = 0; j < 2; j++) begin : g_inst
    localparam int L = (j == 0) ? 1 : 3;
    logic [DW-1:0] mem [512];
    logic [DW-1:0] pipe [4];

    image_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L), .STARVE_MAX(SMAX)) u_dut (
      .clk(clk), .rst(rst),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(dd_w[j]), .disp_valid(dv_w[j]),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(gnt_w[j]), .cpu_rdata(cd_w[j]), .cpu_rvalid(cv_w[j]),
      .ram_addr(ra_w[j]), .ram_wdata(wd_w[j]), .ram_we(we_w[j]), .ram_rdata(rd_w[j]),
      .underrun_cnt(und_w[j])
    );

    initial begin
      for (int k = 0; k < 512; k++) mem[k] = 32'(k) + 32'h100;
      for (int k = 0; k < 4; k++) pipe[k] = 32'h0;
    end

    // RAM: unwritten words read as addr + 0x100; read data L cycles after address
    always @(posedge clk) begin
      if (we_w[j]) mem[ra_w[j][8:0]] <= wd_w[j];
      pipe[0] <= mem[ra_w[j][8:0]];
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign rd_w[j] = pipe[L-1];
  end

  // ---------------- model ----------------
  bit          exp_gnt [NCYC];
  bit          exp_we  [NCYC];
  bit [AW-1:0] exp_wa  [NCYC];
  bit [DW-1:0] exp_wd  [NCYC];
  bit [15:0]   exp_und [NCYC];
  bit          exp_dv  [2][NCYC];
  bit [DW-1:0] exp_dd  [2][NCYC];
  bit          exp_cv  [2][NCYC];
  bit [DW-1:0] exp_cd  [2][NCYC];
  bit [DW-1:0] mem_m   [512];
  int          starve_m = 0;
  int          und_m = 0;
  bit [DW-1:0] last_pix_m = 32'h0;

  bit          obs_gnt [NCYC];
  bit          obs_we  [NCYC];
  bit [AW-1:0] obs_ra  [NCYC];
  bit [15:0]   obs_und [NCYC];
  bit          obs_dv  [2][NCYC];
  bit [DW-1:0] obs_dd  [2][NCYC];
  bit          obs_cv  [2][NCYC];
  bit [DW-1:0] obs_cd  [2][NCYC];

  initial for (int k = 0; k < 512; k++) mem_m[k] = 32'(k) + 32'h100;

  function automatic int lat(input int j);
    return (j == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int c);
    bit          force_m;
    bit          gnt_m;
    bit [DW-1:0] v;
    if (rst) begin
      for (int k = c; k < NCYC; k++) begin
        exp_gnt[k] = 1'b0; exp_we[k] = 1'b0; exp_und[k] = 16'h0;
        for (int j = 0; j < 2; j++) begin exp_dv[j][k] = 1'b0; exp_cv[j][k] = 1'b0; end
      end
      starve_m = 0; und_m = 0; last_pix_m = 32'h0;
    end else if (c + 4 < NCYC) begin
      force_m = GUARD && cpu_req && (starve_m == SMAX);
      gnt_m   = force_m || (cpu_req && !disp_req);
      if (gnt_m) begin
        exp_gnt[c] = 1'b1;
        if (cpu_we) begin
          exp_we[c+1] = 1'b1; exp_wa[c+1] = cpu_addr; exp_wd[c+1] = cpu_wdata;
          mem_m[cpu_addr[8:0]] = cpu_wdata;
        end else begin
          v = mem_m[cpu_addr[8:0]];
          for (int j = 0; j < 2; j++) begin
            exp_cv[j][c+1+lat(j)] = 1'b1; exp_cd[j][c+1+lat(j)] = v;
          end
        end
      end
      if (disp_req) begin
        if (force_m) begin
          v = last_pix_m;
          if (und_m < 65535) und_m++;
        end else begin
          v = mem_m[disp_addr[8:0]];
          last_pix_m = v;
        end
        for (int j = 0; j < 2; j++) begin
          exp_dv[j][c+1+lat(j)] = 1'b1; exp_dd[j][c+1+lat(j)] = v;
        end
      end
      if (!cpu_req || gnt_m) starve_m = 0;
      else if (starve_m < SMAX) starve_m++;
      exp_und[c+1] = 16'(und_m);
    end
  endtask

  task automatic compare_step(input int c);
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("cpu_gnt[%0d]", j), 32'(gnt_w[j]), 32'(exp_gnt[c]));
      chk($sformatf("ram_we[%0d]", j), 32'(we_w[j]), 32'(exp_we[c]));
      if (exp_we[c]) begin
        chk($sformatf("ram_addr[%0d]", j), 32'(ra_w[j]), 32'(exp_wa[c]));
        chk($sformatf("ram_wdata[%0d]", j), wd_w[j], exp_wd[c]);
      end
      chk($sformatf("underrun[%0d]", j), 32'(und_w[j]), 32'(exp_und[c]));
      chk($sformatf("disp_valid[%0d]", j), 32'(dv_w[j]), 32'(exp_dv[j][c]));
      if (exp_dv[j][c]) chk($sformatf("disp_data[%0d]", j), dd_w[j], exp_dd[j][c]);
      chk($sformatf("cpu_rvalid[%0d]", j), 32'(cv_w[j]), 32'(exp_cv[j][c]));
      if (exp_cv[j][c]) chk($sformatf("cpu_rdata[%0d]", j), cd_w[j], exp_cd[j][c]);
    end
  endtask

  // Predict, compare and record on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (cyc < NCYC) begin
      model_step(cyc);
      compare_step(cyc);
      obs_gnt[cyc] <= gnt_w[0];
      obs_we[cyc]  <= we_w[0];
      obs_ra[cyc]  <= ra_w[0];
      obs_und[cyc] <= und_w[0];
      for (int j = 0; j < 2; j++) begin
        obs_dv[j][cyc] <= dv_w[j]; obs_dd[j][cyc] <= dd_w[j];
        obs_cv[j][cyc] <= cv_w[j]; obs_cd[j][cyc] <= cd_w[j];
      end
    end
    last_gnt <= gnt_w[0];
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic dreq, input logic [AW-1:0] daddr);
    @(posedge clk); #1;
    if (last_gnt) cpu_req = 1'b0;
    disp_req  = dreq;
    disp_addr = daddr;
  endtask

  task automatic wait_gnt();
    int n;
    n = 0;
    do begin tick(1'b0, 18'h0); n++; end while (!last_gnt && n < 8);
    chk("cpu_gnt_handshake", 32'(last_gnt), 32'd1);
  endtask

  int t_mid, d0, w, r, s, i0;

  initial begin
    rst = 1'b0; disp_req = 1'b0; disp_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    #1 rst = 1'b1;
    tick(1'b0, 18'h0); tick(1'b0, 18'h0); tick(1'b0, 18'h0);
    rst = 1'b0;
    tick(1'b0, 18'h0); tick(1'b0, 18'h0);

    // reset in the middle of reads
    tick(1'b1, 18'h5); cpu_we = 1'b0; cpu_addr = 18'h7; cpu_req = 1'b1; t_mid = cyc;
    tick(1'b0, 18'h0); rst = 1'b1; cpu_req = 1'b0;
    tick(1'b0, 18'h0); tick(1'b0, 18'h0); rst = 1'b0;
    repeat (5) tick(1'b0, 18'h0);

    // display-only stream
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 18'(i));
      if (i == 0) d0 = cyc;
    end
    repeat (6) tick(1'b0, 18'h0);

    // blanking write then read
    cpu_we = 1'b1; cpu_addr = 18'h10; cpu_wdata = 32'hDEADBEEF; cpu_req = 1'b1; w = cyc;
    wait_gnt();
    cpu_we = 1'b0; cpu_addr = 18'h10; cpu_req = 1'b1; r = cyc;
    wait_gnt();
    repeat (4) tick(1'b0, 18'h0);

    // contention: display and processor both held
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 18'h40 + 18'(i));
      cpu_we = 1'b0; cpu_addr = 18'h20; cpu_req = 1'b1;
      if (i == 0) s = cyc;
    end
    tick(1'b0, 18'h0); cpu_req = 1'b1;
    tick(1'b0, 18'h0);
    repeat (5) tick(1'b0, 18'h0);

    // alternating display / processor reads
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) begin
        tick(1'b1, 18'h80 + 18'(k / 2)); cpu_req = 1'b0;
        if (k == 0) i0 = cyc;
      end else begin
        tick(1'b0, 18'h0);
        cpu_we = 1'b0; cpu_addr = 18'h90 + 18'(k / 2); cpu_req = 1'b1;
      end
    end
    repeat (8) tick(1'b0, 18'h0);

    // hand-computed expectations
    chk("rst_ram_addr", 32'(obs_ra[t_mid+1]), 32'h0);
    chk("rst_drop_dv1", 32'(obs_dv[0][t_mid+2]), 32'h0);
    chk("rst_drop_dv3", 32'(obs_dv[1][t_mid+4]), 32'h0);
    chk("disp_lat_pre", 32'(obs_dv[0][d0+1]), 32'h0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("disp_seq_v%0d", i), 32'(obs_dv[0][d0+2+i]), 32'h1);
      chk($sformatf("disp_seq_d%0d", i), obs_dd[0][d0+2+i], 32'h100 + 32'(i));
    end
    chk("disp3_first", obs_dd[1][d0+4], 32'h100);
    chk("wr_gnt", 32'(obs_gnt[w]), 32'h1);
    chk("wr_we", 32'(obs_we[w+1]), 32'h1);
    chk("wr_we_once", 32'(obs_we[w+2]), 32'h0);
    chk("rd_gnt", 32'(obs_gnt[r]), 32'h1);
    chk("rd_early", 32'(obs_cv[0][r+1]), 32'h0);
    chk("rd_valid", 32'(obs_cv[0][r+2]), 32'h1);
    chk("rd_data", obs_cd[0][r+2], 32'hDEADBEEF);
    chk("starve_no_gnt", 32'(obs_gnt[s+15]), 32'h0);
    chk("starve_gnt1", 32'(obs_gnt[s+16]), GUARD ? 32'h1 : 32'h0);
    chk("starve_gnt2", 32'(obs_gnt[s+33]), GUARD ? 32'h1 : 32'h0);
    chk("starve_und1", 32'(obs_und[s+17]), GUARD ? 32'h1 : 32'h0);
    chk("starve_und2", 32'(obs_und[s+34]), GUARD ? 32'h2 : 32'h0);
    chk("starve_repeat", obs_dd[0][s+18], GUARD ? 32'h14F : 32'h150);
    chk("blank_gnt", 32'(obs_gnt[s+40]), 32'h1);
    chk("il_disp_data", obs_dd[1][i0+4], 32'h180);
    chk("il_cpu_cross", 32'(obs_cv[1][i0+4]), 32'h0);
    chk("il_cpu_valid", 32'(obs_cv[1][i0+5]), 32'h1);
    chk("il_cpu_data", obs_cd[1][i0+5], 32'h190);
    chk("il_disp_cross", 32'(obs_dv[1][i0+5]), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
